// File: rtl/mem_arb_pkg.sv
// Shared types and default timing constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {GNT_I, GNT_D} gnt_e;

  localparam int unsigned DefLat       = 4;
  localparam int unsigned DefStarveMax = 3;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable read-latency down-counter; done flags the cycle where read data is valid.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = DefLat
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int unsigned CntW = $clog2(LAT + 1);
  localparam logic [CntW-1:0] LatV = CntW'(LAT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LatV;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CntW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one fixed-latency memory port,
// D first with a starvation guard for I; flushed fetches complete silently.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LAT        = DefLat,
  parameter int unsigned STARVE_MAX = DefStarveMax
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMaxV = StarveW'(STARVE_MAX);

  state_e              state_q, state_d;
  gnt_e                gnt_q;
  logic [StarveW-1:0]  starve_q;
  logic                kill_q, kill_d;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, i_rdata_q, d_rdata_q;
  logic                di, ii, starved, sel_d, grant, complete, tmr_done;

  // Flush masks requests that have not been issued yet.
  assign di       = ~flush & (d_re | d_we);
  assign ii       = ~flush & i_req;
  assign starved  = ii & (starve_q == StarveMaxV);
  assign sel_d    = di & ~starved;
  assign grant    = (state_q == IDLE) & (di | ii);
  assign complete = (state_q == BUSY) & ~mem_en_q & tmr_done;
  assign kill_d   = (state_q == BUSY) & (kill_q | (flush & (gnt_q == GNT_I)));

  mem_arb_timer #(
    .LAT (LAT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .dec  ((state_q == BUSY) & ~mem_en_q),
    .done (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (complete) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ack = 1'b0;
    d_ack = 1'b0;
    if (state_q == DONE) begin
      if (gnt_q == GNT_D) begin
        d_ack = 1'b1;
      end else begin
        i_ack = ~kill_q & ~flush;
      end
    end
    mem_en    = mem_en_q;
    mem_we    = mem_en_q & mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    stall_if  = i_req & ~i_ack;
    stall_mem = (d_re | d_we) & ~d_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= GNT_I;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q <= grant;
      kill_q   <= kill_d;
      if (grant) begin
        gnt_q       <= sel_d ? GNT_D : GNT_I;
        mem_addr_q  <= sel_d ? d_addr : i_addr;
        mem_we_q    <= sel_d & d_we;
        mem_wdata_q <= sel_d ? d_wdata : '0;
        if (!sel_d) begin
          starve_q <= '0;
        end else if (ii && (starve_q != StarveMaxV)) begin
          starve_q <= starve_q + StarveW'(1);
        end
      end
      if (complete) begin
        if (gnt_q == GNT_D) begin
          d_rdata_q <= mem_we_q ? '0 : mem_rdata;
        end else if (!kill_q && !flush) begin
          i_rdata_q <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned LAT        = 4;
  localparam int unsigned STARVE_MAX = 3;

  logic        clk, rst, flush;
  logic        i_req, i_ack, d_re, d_we, d_ack, stall_if, stall_mem, mem_en, mem_we;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .LAT        (LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_re      (d_re),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Environment memory (driven by the DUT port) and reference memory (driven by the model).
  logic [15:0] env_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] rsched [int];
  int          cyc = 0;
  bit          model_on = 0;

  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rsched.exists(cyc)) begin
        mem_rdata = rsched[cyc];
        rsched.delete(cyc);
      end else begin
        mem_rdata = 16'($urandom);
      end
    end
  end

  // Reference model: one access at a time, tracked by its offset k from the grant cycle.
  bit          m_busy = 0, m_gd = 0, m_we = 0, m_killed = 0;
  int          m_k = 0, m_starve = 0;
  logic [15:0] m_wdata = '0, m_rval = '0, ex_addr = '0, ex_ird = '0, ex_drd = '0;

  initial begin
    forever begin
      bit ex_en, ex_we, ex_iack, ex_dack, di, ii;
      @(negedge clk);
      ex_en   = m_busy && (m_k == 1);
      ex_we   = ex_en && m_we;
      ex_dack = m_busy && m_gd && (m_k == LAT + 2);
      ex_iack = m_busy && !m_gd && (m_k == LAT + 2) && !m_killed && !flush;
      if (model_on) begin
        chk("mem_en", mem_en, ex_en);
        chk("i_ack", i_ack, ex_iack);
        chk("d_ack", d_ack, ex_dack);
        chk("stall_if", stall_if, i_req & ~ex_iack);
        chk("stall_mem", stall_mem, (d_re | d_we) & ~ex_dack);
        chk("i_rdata", i_rdata, ex_ird);
        chk("d_rdata", d_rdata, ex_drd);
        chk("mem_addr", mem_addr, ex_addr);
        if (ex_en) begin
          chk("mem_we", mem_we, ex_we);
          if (ex_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
      end
      if (mem_en === 1'b1) begin
        if (mem_we) env_mem[mem_addr[7:0]] = mem_wdata;
        else rsched[cyc + LAT] = env_mem[mem_addr[7:0]];
      end
      if (rst) begin
        m_busy = 0; m_gd = 0; m_we = 0; m_killed = 0; m_k = 0; m_starve = 0;
        m_wdata = '0; ex_addr = '0; ex_ird = '0; ex_drd = '0;
      end else if (m_busy) begin
        if (!m_gd && flush) m_killed = 1;
        if (m_k == LAT + 1) begin
          if (m_gd) ex_drd = m_we ? 16'h0 : m_rval;
          else if (!m_killed) ex_ird = m_rval;
        end
        if (m_k == LAT + 2) m_busy = 0;
        else m_k++;
      end else begin
        di = !flush && (d_re || d_we);
        ii = !flush && i_req;
        if (di || ii) begin
          m_gd = di && !(ii && (m_starve == STARVE_MAX));
          if (m_gd) begin
            if (ii && m_starve < STARVE_MAX) m_starve++;
            m_we = d_we; ex_addr = d_addr; m_wdata = d_wdata;
          end else begin
            m_starve = 0; m_we = 0; ex_addr = i_addr;
          end
          if (m_we) ref_mem[ex_addr[7:0]] = m_wdata;
          else m_rval = ref_mem[ex_addr[7:0]];
          m_busy = 1; m_k = 1; m_killed = 0;
        end
      end
    end
  end

  // Directed window: bit c of each vector records the output in cycle c.
  logic [63:0] w_en, w_we, w_iack, w_dack, w_sif, w_ord;
  logic [15:0] w_irdata, w_drdata;
  logic [31:0] snap_addr, snap_rd;
  logic [3:0]  snap_ctl;
  int          w_nord;

  task automatic window(input int n, input logic [63:0] fl, input logic [63:0] rs,
                        input logic ir, input logic dr, input logic dw,
                        input logic hold_i, input logic hold_d);
    logic ia, da;
    ia = 0; da = 0;
    w_en = '0; w_we = '0; w_iack = '0; w_dack = '0; w_sif = '0; w_ord = '0; w_nord = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        i_req = ir; d_re = dr; d_we = dw;
      end else begin
        if (ia && !hold_i) i_req = 1'b0;
        if (da && !hold_d) begin d_re = 1'b0; d_we = 1'b0; end
      end
      flush = fl[c];
      rst   = rs[c];
      if (rs[c]) begin i_req = 1'b0; d_re = 1'b0; d_we = 1'b0; end
      #2;
      ia = i_ack; da = d_ack;
      w_en[c] = mem_en; w_we[c] = mem_we; w_iack[c] = i_ack; w_dack[c] = d_ack;
      w_sif[c] = stall_if;
      if (i_ack) w_irdata = i_rdata;
      if (d_ack) w_drdata = d_rdata;
      if (mem_en) begin
        w_ord = {w_ord[62:0], (mem_addr == d_addr)};
        w_nord++;
      end
      if (c == 4) begin
        snap_ctl = {mem_en, mem_we, i_ack, d_ack};
        snap_addr = {mem_addr, mem_wdata};
        snap_rd = {i_rdata, d_rdata};
      end
    end
  endtask

  initial begin
    logic        ia, da;
    int unsigned r;
    rst = 1'b1; flush = 1'b0; i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
    env_mem[8'h20] = 16'h1234; ref_mem[8'h20] = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_on = 1;
    #2;
    chk("reset_ctl", {mem_en, mem_we, i_ack, d_ack, stall_if, stall_mem}, '0);
    chk("reset_addr_wdata", {mem_addr, mem_wdata}, '0);
    chk("reset_rdata", {i_rdata, d_rdata}, '0);

    // Lone fetch.
    i_addr = 16'h0010;
    window(8, '0, '0, 1, 0, 0, 0, 0);
    chk("t1_mem_en", w_en, 64'h2);
    chk("t1_mem_we", w_we, 64'h0);
    chk("t1_i_ack", w_iack, 64'h40);
    chk("t1_i_rdata", w_irdata, 16'hBEEF);
    chk("t1_stall_if", w_sif, 64'h3F);

    // Simultaneous fetch and load: D first.
    d_addr = 16'h0020;
    window(15, '0, '0, 1, 1, 0, 0, 0);
    chk("t2_d_ack", w_dack, 64'h40);
    chk("t2_d_rdata", w_drdata, 16'h1234);
    chk("t2_i_ack", w_iack, 64'h2000);
    chk("t2_stall_if", w_sif, 64'h1FFF);
    chk("t2_mem_en", w_en, 64'h102);

    // Continuous contention: starvation guard every fourth grant.
    i_addr = 16'h0040; d_addr = 16'h0041;
    window(56, '0, '0, 1, 1, 0, 1, 1);
    chk("t3_grants", w_nord, 8);
    chk("t3_order", w_ord, 64'hEE);

    // Flushed fetch completes silently, the retried fetch is served.
    i_addr = 16'h0010;
    window(15, 64'h8, '0, 1, 0, 0, 0, 0);
    chk("t4_mem_en", w_en, 64'h102);
    chk("t4_i_ack", w_iack, 64'h2000);
    chk("t4_i_rdata", w_irdata, 16'hBEEF);

    // Store held off by flush at cycle 0, then read back.
    d_addr = 16'h0030; d_wdata = 16'h5A5A;
    window(9, 64'h1, '0, 0, 0, 1, 0, 0);
    chk("t5_mem_en", w_en, 64'h4);
    chk("t5_mem_we", w_we, 64'h4);
    chk("t5_d_ack", w_dack, 64'h80);
    chk("t5_d_rdata_wr", w_drdata, 16'h0);
    window(8, '0, '0, 0, 1, 0, 0, 0);
    chk("t5_rd_ack", w_dack, 64'h40);
    chk("t5_rd_data", w_drdata, 16'h5A5A);

    // Reset mid-access.
    i_addr = 16'h0010;
    window(10, '0, 64'h8, 1, 0, 0, 0, 0);
    chk("t6_mem_en", w_en, 64'h2);
    chk("t6_acks", w_iack | w_dack, 64'h0);
    chk("t6_snap_ctl", snap_ctl, 4'h0);
    chk("t6_snap_addr", snap_addr, 32'h0);
    chk("t6_snap_rdata", snap_rd, 32'h0);

    // Randomized traffic against the model.
    ia = 0; da = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (ia) i_req = 1'b0;
      if (da) begin d_re = 1'b0; d_we = 1'b0; end
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 16'($urandom_range(0, 31));
      end
      if (!d_re && !d_we && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        d_re = (r != 1);
        d_we = (r == 1) || (r == 2);
        d_addr = 16'($urandom_range(0, 31));
        d_wdata = 16'($urandom);
      end
      flush = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 399) == 0);
      #2;
      ia = i_ack; da = d_ack;
    end
    @(posedge clk);
    #1;
    i_req = 1'b0; d_re = 1'b0; d_we = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
